// File: rtl/flash_boot_loader_pkg.sv
// Shared widths, FSM encoding and sizing helper for the boot-time flash-to-RAM copier.
package flash_boot_loader_pkg;

  localparam int unsigned FlashAw = 22;
  localparam int unsigned RamAw   = 20;
  localparam int unsigned WordW   = 32;
  localparam int unsigned HalfW   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StWr,
    StFin
  } state_e;

  // Counter width able to hold 0..count; never zero so a zero-length copy still elaborates.
  function automatic int unsigned idx_width(input int unsigned count);
    return (count == 0) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads halfword pairs from flash, packs them into words and writes them
// to RAM, holding the CPU stalled until the image copy has finished.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter logic [FlashAw-1:0] FLASH_BASE = '0,
  parameter logic [RamAw-1:0]   RAM_BASE   = '0,
  parameter int unsigned        WORD_COUNT = 1024,
  parameter bit                 AUTO_START = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               flash_req,
  output logic [FlashAw-1:0] flash_addr,
  input  logic               flash_ready,
  input  logic [HalfW-1:0]   flash_rdata,
  output logic               ram_we,
  output logic [RamAw-1:0]   ram_addr,
  output logic [WordW-1:0]   ram_wdata,
  input  logic               ram_ack,
  output logic               busy,
  output logic               done,
  output logic               cpu_stall
);

  localparam int unsigned IdxW = idx_width(WORD_COUNT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'((WORD_COUNT == 0) ? 0 : WORD_COUNT - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [HalfW-1:0] lo_q, lo_d;
  logic [HalfW-1:0] hi_q, hi_d;
  logic             done_q, done_d;
  logic             hold_q, hold_d;
  logic             auto_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      hold_q  <= AUTO_START;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      // Auto-start is only honoured on the first cycle out of reset.
      auto_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = done_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (start || auto_q) begin
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = (WORD_COUNT == 0) ? StFin : StRdLo;
        end
      end
      StRdLo: begin
        if (flash_ready) begin
          lo_d    = flash_rdata;
          state_d = StRdHi;
        end
      end
      StRdHi: begin
        if (flash_ready) begin
          hi_d    = flash_rdata;
          state_d = StWr;
        end
      end
      StWr: begin
        if (ram_ack) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = (idx_q == LastIdx) ? StFin : StRdLo;
        end
      end
      StFin: begin
        // done and release of the boot stall become visible together on return to idle.
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flash_req  = (state_q == StRdLo) || (state_q == StRdHi);
    ram_we     = (state_q == StWr);
    flash_addr = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (flash_req) begin
      flash_addr = FLASH_BASE + (FlashAw'(idx_q) << 1) + FlashAw'(state_q == StRdHi);
    end
    if (ram_we) begin
      ram_addr  = RAM_BASE + RamAw'(idx_q);
      ram_wdata = {hi_q, lo_q};
    end
    busy      = flash_req || ram_we;
    done      = done_q;
    cpu_stall = busy || hold_q;
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: three instances (auto-start, wrapping bases, zero length)
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_flash_boot_loader;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[N], start[N], fready[N], ack[N];
  logic [15:0] rdata[N];
  logic        freq[N], we[N], busy[N], done[N], stall[N];
  logic [21:0] faddr[N];
  logic [19:0] raddr[N];
  logic [31:0] wdata[N];

  flash_boot_loader #(.FLASH_BASE(22'h0), .RAM_BASE(20'h0), .WORD_COUNT(4), .AUTO_START(1'b1))
  u_auto (.clk(clk), .rst(rst[0]), .start(start[0]), .flash_req(freq[0]),
          .flash_addr(faddr[0]), .flash_ready(fready[0]), .flash_rdata(rdata[0]),
          .ram_we(we[0]), .ram_addr(raddr[0]), .ram_wdata(wdata[0]), .ram_ack(ack[0]),
          .busy(busy[0]), .done(done[0]), .cpu_stall(stall[0]));

  flash_boot_loader #(.FLASH_BASE(22'h3FFFFE), .RAM_BASE(20'hFFFFE), .WORD_COUNT(4),
                      .AUTO_START(1'b0))
  u_wrap (.clk(clk), .rst(rst[1]), .start(start[1]), .flash_req(freq[1]),
          .flash_addr(faddr[1]), .flash_ready(fready[1]), .flash_rdata(rdata[1]),
          .ram_we(we[1]), .ram_addr(raddr[1]), .ram_wdata(wdata[1]), .ram_ack(ack[1]),
          .busy(busy[1]), .done(done[1]), .cpu_stall(stall[1]));

  flash_boot_loader #(.FLASH_BASE(22'h0), .RAM_BASE(20'h0), .WORD_COUNT(0), .AUTO_START(1'b0))
  u_zero (.clk(clk), .rst(rst[2]), .start(start[2]), .flash_req(freq[2]),
          .flash_addr(faddr[2]), .flash_ready(fready[2]), .flash_rdata(rdata[2]),
          .ram_we(we[2]), .ram_addr(raddr[2]), .ram_wdata(wdata[2]), .ram_ack(ack[2]),
          .busy(busy[2]), .done(done[2]), .cpu_stall(stall[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each copy is the op list read(2k), read(2k+1), write(k) for k = 0..count-1.
  int          m_wc[N], m_op[N];
  bit          m_act[N], m_fin[N], m_done[N], m_hold[N], m_pend[N], m_auto[N];
  logic [21:0] m_fb[N];
  logic [19:0] m_rb[N];

  int          lat[N], alat[N], cnt[N], nwr[N], nreq[N], edges[N];
  bit          stray[N];
  logic [31:0] wlog[N][4];
  int          done_edge;

  function automatic logic [15:0] hw(input logic [21:0] a);
    return (a[15:0] + 16'd1) * 16'h1111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin : model_and_respond
    int          k, ph;
    logic        e_req, e_we;
    logic [21:0] e_fa;
    logic [19:0] e_ra;
    logic [31:0] e_wd;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        // Advance the model by the edge just passed, using the inputs it sampled.
        if (rst[i]) begin
          m_act[i] = 1'b0; m_op[i] = 0; m_fin[i] = 1'b0; m_done[i] = 1'b0;
          m_hold[i] = m_auto[i]; m_pend[i] = m_auto[i]; edges[i] = 0;
        end else begin
          edges[i]++;
          if (m_fin[i]) begin
            m_fin[i] = 1'b0; m_done[i] = 1'b1; m_hold[i] = 1'b0;
          end else if (!m_act[i]) begin
            if (start[i] || m_pend[i]) begin
              m_done[i] = 1'b0;
              if (m_wc[i] == 0) m_fin[i] = 1'b1;
              else begin m_act[i] = 1'b1; m_op[i] = 0; end
            end
          end else begin
            ph = m_op[i] % 3;
            if ((ph < 2 && fready[i]) || (ph == 2 && ack[i])) begin
              m_op[i]++;
              if (m_op[i] == 3 * m_wc[i]) begin m_act[i] = 1'b0; m_fin[i] = 1'b1; end
            end
          end
          m_pend[i] = 1'b0;
        end

        k     = m_op[i] / 3;
        ph    = m_op[i] % 3;
        e_req = m_act[i] && (ph < 2);
        e_we  = m_act[i] && (ph == 2);
        e_fa  = e_req ? m_fb[i] + 22'(2 * k + ph) : 22'h0;
        e_ra  = e_we ? m_rb[i] + 20'(k) : 20'h0;
        e_wd  = e_we ? {hw(m_fb[i] + 22'(2 * k + 1)), hw(m_fb[i] + 22'(2 * k))} : 32'h0;
        chk($sformatf("u%0d flash_req", i), 32'(freq[i]), 32'(e_req));
        chk($sformatf("u%0d flash_addr", i), 32'(faddr[i]), 32'(e_fa));
        chk($sformatf("u%0d ram_we", i), 32'(we[i]), 32'(e_we));
        chk($sformatf("u%0d ram_addr", i), 32'(raddr[i]), 32'(e_ra));
        chk($sformatf("u%0d ram_wdata", i), wdata[i], e_wd);
        chk($sformatf("u%0d busy", i), 32'(busy[i]), 32'(m_act[i]));
        chk($sformatf("u%0d done", i), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("u%0d cpu_stall", i), 32'(stall[i]), 32'(m_act[i] || m_hold[i]));

        if (i == 0 && done[0] === 1'b1 && done_edge < 0) done_edge = edges[0];
        if (freq[i] === 1'b1) nreq[i]++;

        // Flash/RAM responders; in stray mode the idle handshake line is pulsed while waiting.
        fready[i] = 1'b0; ack[i] = 1'b0; rdata[i] = 16'h0;
        if (freq[i] === 1'b1) begin
          if (cnt[i] >= lat[i]) begin
            fready[i] = 1'b1; rdata[i] = hw(faddr[i]); cnt[i] = 0;
          end else begin
            cnt[i]++;
            if (stray[i]) ack[i] = 1'b1;
          end
        end else if (we[i] === 1'b1) begin
          if (cnt[i] >= alat[i]) begin
            ack[i] = 1'b1;
            if (nwr[i] < 4) wlog[i][nwr[i]] = wdata[i];
            nwr[i]++;
            cnt[i] = 0;
          end else begin
            cnt[i]++;
            if (stray[i]) begin fready[i] = 1'b1; rdata[i] = 16'hDEAD; end
          end
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  task automatic pulse(input int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done[i] === 1'b1) break;
      step();
    end
    chk($sformatf("u%0d done reached", i), 32'(done[i]), 32'd1);
  endtask

  initial begin : stimulus
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; fready[i] = 1'b0; ack[i] = 1'b0; rdata[i] = 16'h0;
      lat[i] = 0; alat[i] = 0; cnt[i] = 0; nwr[i] = 0; nreq[i] = 0; edges[i] = 0;
      stray[i] = 1'b0; m_op[i] = 0; m_act[i] = 1'b0; m_fin[i] = 1'b0; m_done[i] = 1'b0;
      for (int j = 0; j < 4; j++) wlog[i][j] = 32'h0;
    end
    m_wc[0] = 4; m_auto[0] = 1'b1; m_fb[0] = 22'h0;      m_rb[0] = 20'h0;
    m_wc[1] = 4; m_auto[1] = 1'b0; m_fb[1] = 22'h3FFFFE; m_rb[1] = 20'hFFFFE;
    m_wc[2] = 0; m_auto[2] = 1'b0; m_fb[2] = 22'h0;      m_rb[2] = 20'h0;
    m_hold[0] = 1'b1; m_hold[1] = 1'b0; m_hold[2] = 1'b0;
    m_pend[0] = 1'b1; m_pend[1] = 1'b0; m_pend[2] = 1'b0;
    done_edge = -1;

    repeat (3) step();
    chk("reset cpu_stall auto", 32'(stall[0]), 32'd1);
    chk("reset cpu_stall manual", 32'(stall[1]), 32'd0);
    chk("reset flash_req", 32'(freq[0]), 32'd0);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // Auto-start copy with immediate handshakes.
    wait_done(0, 100);
    chk("auto done cycle", 32'(done_edge), 32'd14);
    chk("auto word0", wlog[0][0], 32'h2222_1111);
    chk("auto word3", wlog[0][3], 32'h8888_7777);
    step();
    chk("auto stall released", 32'(stall[0]), 32'd0);

    // Slow flash, plus a start pulse while busy that must be ignored.
    lat[0] = 5; nreq[0] = 0; nwr[0] = 0;
    pulse(0);
    chk("restart clears done", 32'(done[0]), 32'd0);
    repeat (10) step();
    pulse(0);
    chk("busy start ignored", 32'(busy[0]), 32'd1);
    wait_done(0, 400);
    chk("slow req cycles", 32'(nreq[0]), 32'd48);
    chk("slow word1", wlog[0][1], 32'h4444_3333);

    // Restart after done recopies the same image.
    lat[0] = 0; nwr[0] = 0;
    pulse(0);
    chk("recopy clears done", 32'(done[0]), 32'd0);
    wait_done(0, 100);
    chk("recopy word2", wlog[0][2], 32'h6666_5555);

    // Stray handshakes while waiting are ignored.
    stray[0] = 1'b1; lat[0] = 1; alat[0] = 1; nwr[0] = 0;
    pulse(0);
    wait_done(0, 200);
    chk("stray word0", wlog[0][0], 32'h2222_1111);
    chk("stray word3", wlog[0][3], 32'h8888_7777);
    stray[0] = 1'b0;

    // Reset mid-copy on the manual-start instance, then restart from index 0.
    nwr[1] = 0;
    pulse(1);
    for (int c = 0; c < 100 && nwr[1] < 2; c++) step();
    chk("two words before reset", 32'(nwr[1] >= 2), 32'd1);
    step();
    rst[1] = 1'b1;
    step();
    step();
    chk("midreset flash_req", 32'(freq[1]), 32'd0);
    chk("midreset ram_we", 32'(we[1]), 32'd0);
    chk("midreset busy", 32'(busy[1]), 32'd0);
    chk("midreset done", 32'(done[1]), 32'd0);
    chk("midreset cpu_stall", 32'(stall[1]), 32'd0);
    rst[1] = 1'b0;
    repeat (5) step();
    chk("idle until start", 32'(busy[1]), 32'd0);
    nwr[1] = 0;
    pulse(1);
    chk("restart addr idx0", 32'(faddr[1]), 32'h003F_FFFE);
    wait_done(1, 100);
    chk("wrap word0", wlog[1][0], 32'h0000_EEEF);
    chk("wrap word2", wlog[1][2], 32'h4444_3333);

    // Zero-length copy.
    pulse(2);
    step();
    chk("zero count done", 32'(done[2]), 32'd1);
    chk("zero count no req", 32'(nreq[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
